// File: rtl/lmul_vec_pipe.sv
// Lane-parallel logarithmic multiplier with an elastic output pipeline.
// Each lane approximates a*b by adding the biased exponent:mantissa fields
// (Mitchell-style), handles NaN/Inf/zero up front, and reports per-lane
// overflow/underflow. Beats carry a tag and the overflow mode with them.

// Per-lane combinational log-multiply with special-value handling.
module lmul_lane #(
  parameter int E_BITS = 8,
  parameter int M_BITS = 7
) (
  input  logic [E_BITS+M_BITS:0] a,
  input  logic [E_BITS+M_BITS:0] b,
  input  logic                   ovf_inf,
  output logic [E_BITS+M_BITS:0] p,
  output logic                   of,
  output logic                   uf
);
  localparam int EM   = E_BITS + M_BITS;
  localparam int BIAS = (1 << (E_BITS-1)) - 1;
  // Bias and overflow threshold in the fixed-point log domain.
  localparam logic [EM+1:0] BIAS_SH = (EM+2)'(BIAS) << M_BITS;
  localparam logic [EM+1:0] MAX_SH  = (EM+2)'((1 << E_BITS) - 1) << M_BITS;
  localparam logic [EM-1:0] MAXFIN  = EM'(MAX_SH - 1'b1);
  localparam logic [M_BITS-1:0] QM  = M_BITS'(1) << (M_BITS-1);

  logic              sgn;
  logic              a_max, b_max, a_zero, b_zero, nan;
  logic [EM+1:0]     s;

  assign sgn    = a[EM] ^ b[EM];
  assign a_max  = &a[EM-1:M_BITS];
  assign b_max  = &b[EM-1:M_BITS];
  assign a_zero = ~|a[EM-1:M_BITS];
  assign b_zero = ~|b[EM-1:M_BITS];
  assign nan    = (a_max & |a[M_BITS-1:0]) | (b_max & |b[M_BITS-1:0]) |
                  ((a_max | b_max) & (a_zero | b_zero));
  // Two's-complement sum; the top bit is the sign since the range fits EM+2.
  assign s      = {2'b00, a[EM-1:0]} + {2'b00, b[EM-1:0]} - BIAS_SH;

  // Priority: NaN, Inf, zero/subnormal, underflow, overflow, normal.
  always_comb begin
    p  = '0;
    of = 1'b0;
    uf = 1'b0;
    if (nan)                  p = {1'b0, {E_BITS{1'b1}}, QM};
    else if (a_max | b_max)   p = {sgn, {E_BITS{1'b1}}, {M_BITS{1'b0}}};
    else if (a_zero | b_zero) p = '0;
    else if (s[EM+1])         uf = 1'b1;
    else if (s >= MAX_SH) begin
      of = 1'b1;
      p  = ovf_inf ? {sgn, {E_BITS{1'b1}}, {M_BITS{1'b0}}} : {sgn, MAXFIN};
    end
    else                      p = {sgn & (|s[EM-1:0]), s[EM-1:0]};
  end
endmodule

module lmul_vec_pipe #(
  parameter int E_BITS = 8,
  parameter int M_BITS = 7,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_valid,
  output logic                                i_ready,
  input  logic [LANES*(1+E_BITS+M_BITS)-1:0]  i_a,
  input  logic [LANES*(1+E_BITS+M_BITS)-1:0]  i_b,
  input  logic [TAG_W-1:0]                    i_tag,
  input  logic                                i_ovf_inf,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic [LANES*(1+E_BITS+M_BITS)-1:0]  o_p,
  output logic [TAG_W-1:0]                    o_tag,
  output logic [LANES*2-1:0]                  o_flags,
  input  logic                                sticky_clr,
  output logic                                sticky_of,
  output logic                                sticky_uf
);
  localparam int BITW = 1 + E_BITS + M_BITS;

  typedef struct packed {
    logic [LANES-1:0][BITW-1:0] p;
    logic [TAG_W-1:0]           tag;
    logic [LANES-1:0][1:0]      flg;   // {of, uf}
  } beat_t;

  logic [LANES-1:0][BITW-1:0] a_l, b_l, p_l;
  logic [LANES-1:0]           of_l, uf_l;
  beat_t                      beat_in;
  beat_t                      beat_q   [1:STAGES];
  beat_t                      beat_pipe[0:STAGES];
  logic [STAGES:1]            vld_q;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy;
  logic                       o_fire, any_of, any_uf;

  assign a_l = i_a;
  assign b_l = i_b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lmul_lane #(.E_BITS(E_BITS), .M_BITS(M_BITS)) u_lane (
      .a      (a_l[k]),
      .b      (b_l[k]),
      .ovf_inf(i_ovf_inf),
      .p      (p_l[k]),
      .of     (of_l[k]),
      .uf     (uf_l[k])
    );
  end

  // Assemble the incoming beat; mode is consumed here so it travels baked in.
  always_comb begin
    beat_in.p   = p_l;
    beat_in.tag = i_tag;
    for (int k = 0; k < LANES; k++) beat_in.flg[k] = {of_l[k], uf_l[k]};
  end

  // Slot 0 is the input port; slots 1..STAGES are the registers.
  always_comb begin
    vld_pipe     = {vld_q, i_valid};
    beat_pipe[0] = beat_in;
    for (int k = 1; k <= STAGES; k++) beat_pipe[k] = beat_q[k];
  end

  // Backward ready chain: a slot can take data if empty or draining.
  always_comb begin
    rdy[STAGES] = o_ready;
    for (int k = STAGES-1; k >= 0; k--) rdy[k] = ~vld_pipe[k+1] | rdy[k+1];
  end

  assign i_ready = rdy[0];

  // Elastic stage registers; data only moves when the upstream slot is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int k = 1; k <= STAGES; k++) beat_q[k] <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k-1]) begin
          vld_q[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) beat_q[k] <= beat_pipe[k-1];
        end
      end
    end
  end

  assign o_valid = vld_q[STAGES];
  assign o_p     = beat_q[STAGES].p;
  assign o_tag   = beat_q[STAGES].tag;
  assign o_flags = beat_q[STAGES].flg;
  assign o_fire  = o_valid & o_ready;

  // Reduce per-lane flags of the departing beat.
  always_comb begin
    any_of = 1'b0;
    any_uf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      any_of = any_of | beat_q[STAGES].flg[k][1];
      any_uf = any_uf | beat_q[STAGES].flg[k][0];
    end
  end

  // Sticky flags: a set on a consumed beat beats a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_of <= 1'b0;
      sticky_uf <= 1'b0;
    end else begin
      sticky_of <= (o_fire & any_of) | (sticky_of & ~sticky_clr);
      sticky_uf <= (o_fire & any_uf) | (sticky_uf & ~sticky_clr);
    end
  end
endmodule

// File: tb/tb_lmul_vec_pipe.sv
// Bench for lmul_vec_pipe at BF16 defaults (STAGES=2, LANES=4): directed
// scenarios plus a randomized run against a field-arithmetic reference model.
module tb_lmul_vec_pipe;
  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid, i_ready;
  logic [63:0] i_a, i_b;
  logic [3:0]  i_tag;
  logic        i_ovf_inf;
  logic        o_valid, o_ready;
  logic [63:0] o_p;
  logic [3:0]  o_tag;
  logic [7:0]  o_flags;
  logic        sticky_clr, sticky_of, sticky_uf;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct { logic [63:0] p; logic [3:0] tag; logic [7:0] f; } exp_t;

  localparam logic [63:0] BA = {16'hBF80, 16'h4000, 16'h3FC0, 16'h3F80};
  localparam logic [63:0] BB = {16'h4000, 16'h4000, 16'h3FC0, 16'h4000};
  localparam logic [63:0] BP = {16'hC000, 16'h4080, 16'h4000, 16'h4000};

  lmul_vec_pipe dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .i_ovf_inf(i_ovf_inf),
    .o_valid(o_valid), .o_ready(o_ready), .o_p(o_p), .o_tag(o_tag),
    .o_flags(o_flags), .sticky_clr(sticky_clr), .sticky_of(sticky_of),
    .sticky_uf(sticky_uf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: BF16 lane product from the decoded fields, returns {p, of, uf}.
  function automatic logic [17:0] ref_lane(input logic [15:0] a, b, input logic mode);
    int ea = int'(a[14:7]);
    int eb = int'(b[14:7]);
    int ma = int'(a[6:0]);
    int mb = int'(b[6:0]);
    logic sg = a[15] ^ b[15];
    int s;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) ||
        ((ea == 255 || eb == 255) && (ea == 0 || eb == 0)))
      return {16'h7FC0, 2'b00};
    if (ea == 255 || eb == 255) return {sg, 15'h7F80, 2'b00};
    if (ea == 0 || eb == 0) return 18'h0;
    s = (ea * 128 + ma) + (eb * 128 + mb) - 127 * 128;
    if (s < 0) return {16'h0000, 2'b01};
    if (s >= 255 * 128) return mode ? {sg, 15'h7F80, 2'b10} : {sg, 15'h7F7F, 2'b10};
    if (s == 0) return 18'h0;
    return {sg, 15'(s), 2'b00};
  endfunction

  function automatic exp_t ref_beat(input logic [63:0] a, b, input logic [3:0] tag, input logic mode);
    exp_t e;
    logic [17:0] r;
    e.tag = tag;
    e.p = '0;
    e.f = '0;
    for (int k = 0; k < 4; k++) begin
      r = ref_lane(a[k*16 +: 16], b[k*16 +: 16], mode);
      e.p[k*16 +: 16] = r[17:2];
      e.f[k*2 +: 2]   = r[1:0];
    end
    return e;
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 11))
      0: return 16'h0000;
      1: return 16'h7F80;
      2: return 16'hFFC1;
      3: return 16'h0080;
      4: return 16'h7F00;
      5: return 16'h3F80;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drive one beat with o_ready high; report result and cycles to o_valid.
  task automatic run_beat(input logic [63:0] a, b, input logic [3:0] tag, input logic mode,
                          output logic [63:0] p, output logic [7:0] f,
                          output logic [3:0] tg, output int lat);
    lat = -1; p = '0; f = '0; tg = '0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_a = a; i_b = b; i_tag = tag; i_ovf_inf = mode; o_ready = 1'b1;
    #1;
    for (int c = 0; c < 10 && !i_ready; c++) begin @(posedge clk); #2; end
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = '0; i_b = '0; i_ovf_inf = ~mode;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (o_valid) begin lat = c; p = o_p; f = o_flags; tg = o_tag; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_valid = 1'b1; i_a = BA; i_b = BB; i_tag = 4'h3;
    i_ovf_inf = 1'b0; o_ready = 1'b1; sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (o_valid !== 1'b0) $display("FAIL rst_o_valid got=%b exp=0", o_valid); else n_pass++;
    n_chk++; if ({o_p, o_tag, o_flags} !== 76'h0) $display("FAIL rst_outputs got=%h exp=0", {o_p, o_tag, o_flags}); else n_pass++;
    n_chk++; if ({sticky_of, sticky_uf} !== 2'b00) $display("FAIL rst_sticky got=%b exp=00", {sticky_of, sticky_uf}); else n_pass++;
    n_chk++; if (i_ready !== 1'b1) $display("FAIL rst_i_ready got=%b exp=1", i_ready); else n_pass++;
    #2 rstn = 1'b1;
    @(posedge clk); #1;   // first edge after release takes the beat
    i_valid = 1'b0;
    n_chk++; if (o_valid !== 1'b0) $display("FAIL rst_first_lat1 got=%b exp=0", o_valid); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (o_valid !== 1'b1) $display("FAIL rst_first_lat2 got=%b exp=1", o_valid); else n_pass++;
    n_chk++; if ({o_p, o_tag} !== {BP, 4'h3}) $display("FAIL rst_first_beat got=%h exp=%h", {o_p, o_tag}, {BP, 4'h3}); else n_pass++;
  endtask

  task automatic test_basic();
    logic [63:0] p; logic [7:0] f; logic [3:0] tg; int lat;
    run_beat(BA, BB, 4'h5, 1'b0, p, f, tg, lat);
    n_chk++; if (lat !== 2) $display("FAIL basic_latency got=%0d exp=2", lat); else n_pass++;
    n_chk++; if (p !== BP) $display("FAIL basic_p got=%h exp=%h", p, BP); else n_pass++;
    n_chk++; if ({f, tg} !== {8'h00, 4'h5}) $display("FAIL basic_flags_tag got=%h exp=%h", {f, tg}, {8'h00, 4'h5}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nout = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      i_valid = (c < 6); i_a = BA; i_b = BB; i_tag = 4'(c + 1); o_ready = 1'b1;
      #1;
      if (c < 6) begin
        n_chk++; if (i_ready !== 1'b1) $display("FAIL b2b_i_ready c=%0d got=%b exp=1", c, i_ready); else n_pass++;
      end
      n_chk++; if (o_valid !== (c >= 2 && c < 8)) $display("FAIL b2b_o_valid c=%0d got=%b", c, o_valid); else n_pass++;
      if (o_valid) begin
        nout++;
        n_chk++; if (o_tag !== 4'(c - 1)) $display("FAIL b2b_tag c=%0d got=%h exp=%h", c, o_tag, 4'(c - 1)); else n_pass++;
      end
    end
    i_valid = 1'b0;
    n_chk++; if (nout !== 6) $display("FAIL b2b_count got=%0d exp=6", nout); else n_pass++;
  endtask

  task automatic test_special();
    logic [63:0] p; logic [7:0] f; logic [3:0] tg; int lat;
    run_beat({16'h7F80, 16'h7FC0, 16'h8000, 16'h0080}, {16'h0000, 16'h3F80, 16'h3F80, 16'h0080},
             4'h1, 1'b0, p, f, tg, lat);
    n_chk++; if ({p, f} !== {64'h7FC0_7FC0_0000_0000, 8'h01}) $display("FAIL special1 got=%h exp=%h", {p, f}, {64'h7FC0_7FC0_0000_0000, 8'h01}); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (sticky_uf !== 1'b1) $display("FAIL sticky_uf_set got=%b exp=1", sticky_uf); else n_pass++;
    run_beat({16'h4000, 16'h0000, 16'h3F80, 16'hFF80}, {16'hC000, 16'h7F80, 16'hFFC1, 16'h3F80},
             4'h2, 1'b0, p, f, tg, lat);
    n_chk++; if ({p, f} !== {64'hC080_7FC0_7FC0_FF80, 8'h00}) $display("FAIL special2 got=%h exp=%h", {p, f}, {64'hC080_7FC0_7FC0_FF80, 8'h00}); else n_pass++;
    // exact-zero sum, smallest positive sum, just below and at the overflow threshold
    run_beat({16'h7F7F, 16'h7F7F, 16'h0081, 16'h8080}, {16'h3F81, 16'h3F80, 16'hBF00, 16'h3F00},
             4'h3, 1'b0, p, f, tg, lat);
    n_chk++; if ({p, f} !== {64'h7F7F_7F7F_8001_0000, 8'h80}) $display("FAIL special3 got=%h exp=%h", {p, f}, {64'h7F7F_7F7F_8001_0000, 8'h80}); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] p; logic [7:0] f; logic [3:0] tg; int lat;
    logic [63:0] oa, ob;
    oa = {16'h3F80, 16'h3F80, 16'hFF00, 16'h7F00};
    ob = {16'h3F80, 16'h3F80, 16'h7F00, 16'h7F00};
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    n_chk++; if (sticky_of !== 1'b0) $display("FAIL sticky_of_clr0 got=%b exp=0", sticky_of); else n_pass++;
    run_beat(oa, ob, 4'h6, 1'b0, p, f, tg, lat);
    n_chk++; if ({p, f} !== {64'h3F80_3F80_FF7F_7F7F, 8'h0A}) $display("FAIL ovf_sat got=%h exp=%h", {p, f}, {64'h3F80_3F80_FF7F_7F7F, 8'h0A}); else n_pass++;
    run_beat(oa, ob, 4'h7, 1'b1, p, f, tg, lat);
    n_chk++; if ({p, f} !== {64'h3F80_3F80_FF80_7F80, 8'h0A}) $display("FAIL ovf_inf got=%h exp=%h", {p, f}, {64'h3F80_3F80_FF80_7F80, 8'h0A}); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (sticky_of !== 1'b1) $display("FAIL sticky_of_hold got=%b exp=1", sticky_of); else n_pass++;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (sticky_of !== 1'b0) $display("FAIL sticky_of_clear got=%b exp=0", sticky_of); else n_pass++;
    // clear held across the consuming edge: the set must win
    run_beat(oa, ob, 4'h8, 1'b0, p, f, tg, lat);
    @(posedge clk); #1;
    n_chk++; if (sticky_of !== 1'b1) $display("FAIL sticky_set_wins got=%b exp=1", sticky_of); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (sticky_of !== 1'b0) $display("FAIL sticky_clr_after got=%b exp=0", sticky_of); else n_pass++;
    sticky_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    int nxt = 1, nacc = 0, nout = 0;
    logic [3:0] got[3];
    for (int c = 0; c < 20 && nout < 3; c++) begin
      @(posedge clk); #1;
      i_valid = (nxt <= 3); i_a = BA; i_b = BB; i_tag = 4'(nxt); o_ready = (c >= 5);
      #1;
      if (c == 2) begin
        n_chk++; if (i_ready !== 1'b0) $display("FAIL bp_i_ready_low got=%b exp=0", i_ready); else n_pass++;
      end
      if (c == 4) begin
        n_chk++; if (nacc !== 2) $display("FAIL bp_accepts got=%0d exp=2", nacc); else n_pass++;
        n_chk++; if ({o_valid, o_tag, o_p} !== {1'b1, 4'h1, BP}) $display("FAIL bp_hold got=%h exp=%h", {o_valid, o_tag, o_p}, {1'b1, 4'h1, BP}); else n_pass++;
      end
      if (i_valid && i_ready) begin nxt++; nacc++; end
      if (o_valid && o_ready) begin got[nout] = o_tag; nout++; end
    end
    i_valid = 1'b0;
    n_chk++; if (nout !== 3) $display("FAIL bp_out_count got=%0d exp=3", nout); else n_pass++;
    n_chk++; if ({got[0], got[1], got[2]} !== 12'h123) $display("FAIL bp_order got=%h exp=123", {got[0], got[1], got[2]}); else n_pass++;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, held;
    logic hold_v = 1'b0;
    logic m_sof = 1'b0, m_suf = 1'b0;
    logic in_f, out_f, exp_rdy;
    int nbeats = 0, nout = 0;
    @(posedge clk); #1;
    i_valid = 1'b0; o_ready = 1'b0; sticky_clr = 1'b1;
    for (int c = 0; c < 60000 && nbeats < 10000; c++) begin
      @(posedge clk); #1;
      n_chk++; if ({sticky_of, sticky_uf} !== {m_sof, m_suf}) $display("FAIL rnd_sticky c=%0d got=%b exp=%b", c, {sticky_of, sticky_uf}, {m_sof, m_suf}); else n_pass++;
      if (hold_v) begin
        n_chk++;
        if ({o_valid, o_p, o_tag, o_flags} !== {1'b1, held.p, held.tag, held.f})
          $display("FAIL rnd_stable c=%0d got=%h exp=%h", c, {o_valid, o_p, o_tag, o_flags}, {1'b1, held.p, held.tag, held.f});
        else n_pass++;
      end
      i_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      i_tag = 4'($urandom); i_ovf_inf = 1'($urandom);
      for (int k = 0; k < 4; k++) begin i_a[k*16 +: 16] = rnd_op(); i_b[k*16 +: 16] = rnd_op(); end
      #1;
      exp_rdy = !(q.size() == 2 && !o_ready);
      n_chk++; if (i_ready !== exp_rdy) $display("FAIL rnd_i_ready c=%0d got=%b exp=%b", c, i_ready, exp_rdy); else n_pass++;
      in_f  = i_valid && i_ready;
      out_f = o_valid && o_ready;
      e.f = '0;
      if (out_f) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL rnd_spurious c=%0d got tag=%h exp=none", c, o_tag);
        else begin
          e = q.pop_front();
          if ({o_p, o_tag, o_flags} !== {e.p, e.tag, e.f})
            $display("FAIL rnd_beat n=%0d got=%h exp=%h", nout, {o_p, o_tag, o_flags}, {e.p, e.tag, e.f});
          else n_pass++;
        end
        nout++;
      end
      m_sof = (out_f && (e.f[1] | e.f[3] | e.f[5] | e.f[7])) || (m_sof && !sticky_clr);
      m_suf = (out_f && (e.f[0] | e.f[2] | e.f[4] | e.f[6])) || (m_suf && !sticky_clr);
      if (in_f) begin q.push_back(ref_beat(i_a, i_b, i_tag, i_ovf_inf)); nbeats++; end
      hold_v = o_valid && !o_ready;
      held.p = o_p; held.tag = o_tag; held.f = o_flags;
      if (n_chk - n_pass > 20) break;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; o_ready = 1'b1; sticky_clr = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      if (o_valid) begin
        e = q.pop_front();
        n_chk++;
        if ({o_p, o_tag, o_flags} !== {e.p, e.tag, e.f})
          $display("FAIL rnd_drain got=%h exp=%h", {o_p, o_tag, o_flags}, {e.p, e.tag, e.f});
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_chk++; if (q.size() !== 0) $display("FAIL rnd_lost got=%0d exp=0 beats outstanding", q.size()); else n_pass++;
    n_chk++; if (nbeats !== 10000) $display("FAIL rnd_beats got=%0d exp=10000", nbeats); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    logic [63:0] p; logic [7:0] f; logic [3:0] tg; int lat;
    run_beat({16'h3F80, 16'h3F80, 16'h3F80, 16'h7F00}, {16'h3F80, 16'h3F80, 16'h3F80, 16'h7F00},
             4'h4, 1'b0, p, f, tg, lat);
    @(posedge clk); #1;
    n_chk++; if (sticky_of !== 1'b1) $display("FAIL rif_sticky_pre got=%b exp=1", sticky_of); else n_pass++;
    i_valid = 1'b1; i_a = BA; i_b = BB; i_tag = 4'h9; o_ready = 1'b0;
    @(posedge clk); #1 i_tag = 4'hA;
    @(posedge clk); #1 i_valid = 1'b0;
    n_chk++; if (o_valid !== 1'b1) $display("FAIL rif_inflight got=%b exp=1", o_valid); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_chk++; if ({o_valid, o_p, o_tag, o_flags} !== 77'h0) $display("FAIL rif_async_clear got=%h exp=0", {o_valid, o_p, o_tag, o_flags}); else n_pass++;
    n_chk++; if ({sticky_of, sticky_uf, i_ready} !== 3'b001) $display("FAIL rif_sticky_ready got=%b exp=001", {sticky_of, sticky_uf, i_ready}); else n_pass++;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_chk++; if (o_valid !== 1'b0) $display("FAIL rif_stale c=%0d got=%b exp=0", c, o_valid); else n_pass++;
    end
    run_beat(BA, BB, 4'hB, 1'b0, p, f, tg, lat);
    n_chk++; if (lat !== 2) $display("FAIL rif_latency got=%0d exp=2", lat); else n_pass++;
    n_chk++; if ({p, tg} !== {BP, 4'hB}) $display("FAIL rif_next_beat got=%h exp=%h", {p, tg}, {BP, 4'hB}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_special();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
